clk_en_supervisor: RTL and testbench

Parametrised successor to the fixed single-output PLL wrapper. It supervises an asynchronous PLL lock flag and holds a synchronous design reset until lock has been stable for a programmable time. Once running, it produces NUM_CH independent, runtime-reprogrammable clock-enable pulses and square waves from the PLL output clock. It sits directly after the PLL and feeds reset and enables to peripheral drivers (LCD, Pmod, UART) without adding clock domains.

---
 rtl/clk_en_supervisor.sv | 165 ++++++++++++++++
 tb/tb_clk_en_supervisor.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/clk_en_supervisor.sv
// rtl/clk_en_supervisor.sv - PLL lock supervisor with reset release and NUM_CH programmable clock enables
// Holds rst_out_n low until lock is stable; then drives per-channel ce pulses and sq waves.
module clk_en_supervisor #(
  parameter int NUM_CH    = 2,
  parameter int DIV_W     = 16,
  parameter int LOCK_SYNC = 2,
  parameter int LOCK_WAIT = 1024,
  parameter int DEF_DIV   = 27000,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              rst_out_n,
  output logic              locked,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] sq
);

  localparam int SC_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [SC_W-1:0] STAB_LAST = SC_W'(LOCK_WAIT - 1);
  localparam logic [CH_W:0]   NUM_CH_X  = (CH_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN} state_t;

  state_t               r_state;
  logic [SC_W-1:0]      r_stab;
  logic [LOCK_SYNC-1:0] r_sync;
  logic                 r_rst_out_n;
  logic                 r_locked;

  logic                 r_pend;
  logic [CH_W-1:0]      r_pch;
  logic [DIV_W-1:0]     r_pdiv;

  logic [DIV_W-1:0]     r_div [NUM_CH];
  logic [DIV_W-1:0]     r_cnt [NUM_CH];
  logic [NUM_CH-1:0]    r_ce;
  logic [NUM_CH-1:0]    r_sq;

  logic                 w_lk;
  logic                 w_run_nxt;
  logic                 w_pch_bad;
  logic [NUM_CH-1:0]    w_wrap;
  logic [NUM_CH-1:0]    w_apply;
  logic [NUM_CH-1:0]    w_ce_nxt;
  logic [NUM_CH-1:0]    w_sq_nxt;
  logic [DIV_W-1:0]     w_n       [NUM_CH];
  logic [DIV_W-1:0]     w_div_nxt [NUM_CH];
  logic [DIV_W-1:0]     w_n_nxt   [NUM_CH];
  logic [DIV_W-1:0]     w_cnt_nxt [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[LOCK_SYNC-2:0], pll_lock};
    end
  end

  assign w_lk = r_sync[LOCK_SYNC-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WAIT_LOCK;
      r_stab      <= '0;
      r_rst_out_n <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          r_stab <= '0;
          if (w_lk) r_state <= STABLE;
        end
        STABLE: begin
          if (!w_lk) begin
            r_state <= WAIT_LOCK;
            r_stab  <= '0;
          end else if (r_stab == STAB_LAST) begin
            r_state     <= RUN;
            r_stab      <= '0;
            r_rst_out_n <= 1'b1;
            r_locked    <= 1'b1;
          end else begin
            r_stab <= r_stab + SC_W'(1);
          end
        end
        RUN: begin
          if (!w_lk) begin
            r_state     <= WAIT_LOCK;
            r_rst_out_n <= 1'b0;
            r_locked    <= 1'b0;
          end
        end
        default: begin
          r_state     <= WAIT_LOCK;
          r_stab      <= '0;
          r_rst_out_n <= 1'b0;
          r_locked    <= 1'b0;
        end
      endcase
    end
  end

  // Mirrors the FSM transition so channel outputs line up with the first RUN cycle.
  assign w_run_nxt = w_lk && ((r_state == RUN) || ((r_state == STABLE) && (r_stab == STAB_LAST)));
  assign w_pch_bad = ({1'b0, r_pch} >= NUM_CH_X);

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      w_n[k]       = (r_div[k] == '0) ? DIV_W'(1) : r_div[k];
      w_wrap[k]    = r_locked && (r_cnt[k] == (w_n[k] - DIV_W'(1)));
      w_apply[k]   = r_pend && (r_pch == CH_W'(k)) && (!r_locked || w_wrap[k]);
      w_div_nxt[k] = w_apply[k] ? r_pdiv : r_div[k];
      w_n_nxt[k]   = (w_div_nxt[k] == '0) ? DIV_W'(1) : w_div_nxt[k];
      w_cnt_nxt[k] = (w_run_nxt && r_locked && !w_wrap[k]) ? (r_cnt[k] + DIV_W'(1)) : '0;
      w_ce_nxt[k]  = w_run_nxt && w_wrap[k];
      // Half-point uses the divide of the period being entered, so a new N shapes sq at once.
      w_sq_nxt[k]  = w_run_nxt && (w_cnt_nxt[k] >= (w_n_nxt[k] >> 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
      r_pch  <= '0;
      r_pdiv <= '0;
    end else if (cfg_valid && !r_pend) begin
      r_pend <= 1'b1;
      r_pch  <= cfg_ch;
      r_pdiv <= cfg_div;
    end else if (r_pend && (w_pch_bad || (|w_apply))) begin
      r_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_div[k] <= DIV_W'(DEF_DIV);
        r_cnt[k] <= '0;
      end
      r_ce <= '0;
      r_sq <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_div[k] <= w_div_nxt[k];
        r_cnt[k] <= w_cnt_nxt[k];
      end
      r_ce <= w_ce_nxt;
      r_sq <= w_sq_nxt;
    end
  end

  assign cfg_ready = !r_pend;
  assign rst_out_n = r_rst_out_n;
  assign locked    = r_locked;
  assign ce        = r_ce;
  assign sq        = r_sq;

endmodule

// File: tb/tb_clk_en_supervisor.sv
// tb/tb_clk_en_supervisor.sv - directed bench for clk_en_supervisor
// Three channels so that an out-of-range channel index is representable.
module tb_clk_en_supervisor;

  localparam int NUM_CH    = 3;
  localparam int DIV_W     = 8;
  localparam int LOCK_SYNC = 2;
  localparam int LOCK_WAIT = 8;
  localparam int DEF_DIV   = 4;
  localparam int CH_W      = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pll_lock = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic              rst_out_n;
  logic              locked;
  logic [NUM_CH-1:0] ce;
  logic [NUM_CH-1:0] sq;

  int n_vec = 0;
  int n_err = 0;

  clk_en_supervisor #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_SYNC(LOCK_SYNC),
    .LOCK_WAIT(LOCK_WAIT), .DEF_DIV(DEF_DIV), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .rst_out_n(rst_out_n), .locked(locked), .ce(ce), .sq(sq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s@%0d observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n0, c2, ca;
    logic [2:0] ece, esq;

    tick(); tick();
    chk("rst_rst_out_n", 0, 8'(rst_out_n), 8'd0);
    chk("rst_locked", 0, 8'(locked), 8'd0);
    chk("rst_ce", 0, 8'(ce), 8'd0);
    chk("rst_sq", 0, 8'(sq), 8'd0);
    chk("rst_cfg_ready", 0, 8'(cfg_ready), 8'd1);
    rst_n = 1'b1;
    tick();

    // Set channel 1 to N=1 before lock: applies immediately.
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd1;
    tick();
    cfg_valid = 1'b0;
    chk("pre_run_ready_low", 0, 8'(cfg_ready), 8'd0);
    tick();
    chk("pre_run_ready_high", 0, 8'(cfg_ready), 8'd1);

    pll_lock = 1'b1;
    for (int t = 1; t <= 11; t++) begin
      tick();
      chk("lock_rst_out_n", t, 8'(rst_out_n), 8'(t == 11));
      chk("lock_locked", t, 8'(locked), 8'(t == 11));
      if (t < 11) begin
        chk("lock_ce", t, 8'(ce), 8'd0);
        chk("lock_sq", t, 8'(sq), 8'd0);
      end
    end

    // RUN cycles C0..C38: ch0 N=4 then N=6 from C12, ch1 N=1, ch2 N=4.
    for (int i = 0; i <= 38; i++) begin
      if (i < 12) begin c0 = i % 4; n0 = 4; end
      else begin c0 = (i - 12) % 6; n0 = 6; end
      c2  = i % 4;
      ece = {(c2 == 0) && (i > 0), (i > 0), (c0 == 0) && (i > 0)};
      esq = {c2 >= 2, 1'b1, c0 >= (n0 / 2)};
      chk("run_ce", i, 8'(ce), 8'(ece));
      chk("run_sq", i, 8'(sq), 8'(esq));
      chk("run_cfg_ready", i, 8'(cfg_ready), 8'(!(i == 10 || i == 11 || i == 25)));
      chk("run_rst_out_n", i, 8'(rst_out_n), 8'd1);
      if (i == 9)  begin cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd6; end
      if (i == 10) cfg_valid = 1'b0;
      if (i == 24) begin cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd2; end
      if (i == 25) cfg_valid = 1'b0;
      if (i == 36) pll_lock = 1'b0;
      tick();
    end

    chk("drop_rst_out_n", 39, 8'(rst_out_n), 8'd0);
    chk("drop_locked", 39, 8'(locked), 8'd0);
    chk("drop_ce", 39, 8'(ce), 8'd0);
    chk("drop_sq", 39, 8'(sq), 8'd0);

    // Relock with a one-cycle lk glitch while the stable counter is at 5.
    pll_lock = 1'b1;
    for (int t = 1; t <= 18; t++) begin
      tick();
      if (t == 6) pll_lock = 1'b0;
      if (t == 7) pll_lock = 1'b1;
      chk("relock_rst_out_n", t, 8'(rst_out_n), 8'(t == 18));
      chk("relock_locked", t, 8'(locked), 8'(t == 18));
    end

    for (int r = 0; r <= 12; r++) begin
      c0  = r % 6;
      c2  = r % 4;
      ece = {(c2 == 0) && (r > 0), (r > 0), (c0 == 0) && (r > 0)};
      esq = {c2 >= 2, 1'b1, c0 >= 3};
      chk("retain_ce", r, 8'(ce), 8'(ece));
      chk("retain_sq", r, 8'(sq), 8'(esq));
      tick();
    end

    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2;
    tick();
    cfg_valid = 1'b0;
    chk("pend_before_rst", 0, 8'(cfg_ready), 8'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rst_out_n", 0, 8'(rst_out_n), 8'd0);
    chk("arst_locked", 0, 8'(locked), 8'd0);
    chk("arst_ce", 0, 8'(ce), 8'd0);
    chk("arst_sq", 0, 8'(sq), 8'd0);
    chk("arst_cfg_ready", 0, 8'(cfg_ready), 8'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 1; t <= 11; t++) begin
      tick();
      chk("rerun_rst_out_n", t, 8'(rst_out_n), 8'(t == 11));
    end

    // After rst_n every channel is back at DEF_DIV=4 and the pending write is gone.
    for (int r = 0; r <= 8; r++) begin
      ca = r % 4;
      chk("default_ce", r, 8'(ce), ((ca == 0) && (r > 0)) ? 8'h07 : 8'h00);
      chk("default_sq", r, 8'(sq), (ca >= 2) ? 8'h07 : 8'h00);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
